// File: rtl/issue_queue.sv
// Out-of-order issue queue sitting directly after register renaming.
// Holds up to DEPTH renamed instructions, tracks source readiness from
// writeback wakeups, and offers the oldest ready entry for issue each cycle.
// Optional feature macro: IQ_ENQ_WAKEUP_BYPASS_EN. When defined, a wakeup in
// the enqueue cycle also marks the incoming entry's matching sources ready.
module issue_queue #(
    parameter int DEPTH     = 16,
    parameter int PTAG_W    = 6,
    parameter int SEQ_W     = 32,
    parameter int PAYLOAD_W = 96
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [PTAG_W-1:0]          enq_rs_tag,
    input  logic [PTAG_W-1:0]          enq_rt_tag,
    input  logic                       enq_uses_rs,
    input  logic                       enq_uses_rt,
    input  logic                       enq_rs_rdy,
    input  logic                       enq_rt_rdy,
    input  logic [PTAG_W-1:0]          enq_rw_tag,
    input  logic [SEQ_W-1:0]           enq_seq,
    input  logic [PAYLOAD_W-1:0]       enq_payload,
    input  logic                       wakeup_valid,
    input  logic [PTAG_W-1:0]          wakeup_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PTAG_W-1:0]          iss_rs_tag,
    output logic [PTAG_W-1:0]          iss_rt_tag,
    output logic [PTAG_W-1:0]          iss_rw_tag,
    output logic [SEQ_W-1:0]           iss_seq,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    input  logic                       flush,
    input  logic                       squash_valid,
    input  logic [SEQ_W-1:0]           squash_seq,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    typedef struct packed {
        logic                 vld;
        logic                 uses_rs;
        logic                 uses_rt;
        logic                 rs_rdy;
        logic                 rt_rdy;
        logic [PTAG_W-1:0]    rs_tag;
        logic [PTAG_W-1:0]    rt_tag;
        logic [PTAG_W-1:0]    rw_tag;
        logic [SEQ_W-1:0]     seq;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    ent_t ent_q [DEPTH];
    ent_t ent_d [DEPTH];

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] oldest;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [OCC_W-1:0] occ_cnt;
    logic             enq_fire;
    logic             iss_fire;
    logic             enq_rs_rdy_eff;
    logic             enq_rt_rdy_eff;

    // Population count of valid entries; enq_ready is based on this current value
    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + OCC_W'(ent_q[i].vld);
        end
    end

    assign occupancy = occ_cnt;
    assign enq_ready = (occ_cnt < OCC_W'(DEPTH)) && !flush && !squash_valid;
    assign enq_fire  = enq_valid && enq_ready;

    // Candidate = valid entry whose needed sources are all ready
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cand[i] = ent_q[i].vld &&
                      (!ent_q[i].uses_rs || ent_q[i].rs_rdy) &&
                      (!ent_q[i].uses_rt || ent_q[i].rt_rdy);
        end
    end

    // Wrap-safe age matrix: an entry wins if it is older than every other candidate
    always_comb begin
        logic [SEQ_W-1:0] diff;
        diff = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j]) begin
                    diff = ent_q[i].seq - ent_q[j].seq;
                    if (!($signed(diff) < 0 || (diff == '0 && i < j))) begin
                        oldest[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Resolve the winner index and the lowest free slot for enqueue
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!ent_q[i].vld && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Issue port: offer nothing while the queue is being flushed or squashed
    always_comb begin
        iss_valid   = sel_found && !flush && !squash_valid;
        iss_rs_tag  = '0;
        iss_rt_tag  = '0;
        iss_rw_tag  = '0;
        iss_seq     = '0;
        iss_payload = '0;
        if (sel_found) begin
            iss_rs_tag  = ent_q[sel_idx].rs_tag;
            iss_rt_tag  = ent_q[sel_idx].rt_tag;
            iss_rw_tag  = ent_q[sel_idx].rw_tag;
            iss_seq     = ent_q[sel_idx].seq;
            iss_payload = ent_q[sel_idx].payload;
        end
    end

    assign iss_fire = iss_valid && iss_ready;

`ifdef IQ_ENQ_WAKEUP_BYPASS_EN
    // Catch a producer that writes back in the same cycle its consumer renames
    always_comb begin
        enq_rs_rdy_eff = enq_rs_rdy || (wakeup_valid && (wakeup_tag == enq_rs_tag));
        enq_rt_rdy_eff = enq_rt_rdy || (wakeup_valid && (wakeup_tag == enq_rt_tag));
    end
`else
    // Incoming readiness comes from the rename busy table only
    always_comb begin
        enq_rs_rdy_eff = enq_rs_rdy;
        enq_rt_rdy_eff = enq_rt_rdy;
    end
`endif

    // Next-state: wakeup, issue-free, enqueue, then squash and flush override validity
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].vld && wakeup_valid) begin
                if (ent_q[i].rs_tag == wakeup_tag) ent_d[i].rs_rdy = 1'b1;
                if (ent_q[i].rt_tag == wakeup_tag) ent_d[i].rt_rdy = 1'b1;
            end
            if (iss_fire && sel_idx == IDX_W'(i)) begin
                ent_d[i].vld = 1'b0;
            end
            if (enq_fire && free_idx == IDX_W'(i)) begin
                ent_d[i].vld     = 1'b1;
                ent_d[i].uses_rs = enq_uses_rs;
                ent_d[i].uses_rt = enq_uses_rt;
                ent_d[i].rs_rdy  = enq_rs_rdy_eff;
                ent_d[i].rt_rdy  = enq_rt_rdy_eff;
                ent_d[i].rs_tag  = enq_rs_tag;
                ent_d[i].rt_tag  = enq_rt_tag;
                ent_d[i].rw_tag  = enq_rw_tag;
                ent_d[i].seq     = enq_seq;
                ent_d[i].payload = enq_payload;
            end
            if (squash_valid && ent_q[i].vld &&
                ($signed(ent_q[i].seq - squash_seq) > 0)) begin
                ent_d[i].vld = 1'b0;
            end
            if (flush) begin
                ent_d[i].vld = 1'b0;
            end
        end
    end

    // Entry storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
